// File: rtl/cbus_arbiter_pkg.sv
// Shared CBus request/response types plus the small helpers used by the arbiter.
// The types are plain packed structs, so any CBus block can route them as opaque words.
package cbus_arbiter_pkg;

  localparam int CBUS_MAX_INPUTS = 8;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  strobe;
    logic [31:0] data;
    logic [7:0]  len;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

  // Single-step modulo: callers never exceed 2*n-1.
  function automatic int rr_wrap(input int v, input int n);
    return (v >= n) ? (v - n) : v;
  endfunction

endpackage

// File: rtl/cbus_arbiter_rr_picker.sv
// Combinational round-robin picker: first set bit of valid at or after rr_ptr, wrapping.
// Zero latency; found=0 when no requester is valid.
module cbus_arbiter_rr_picker
  import cbus_arbiter_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] rr_ptr,
  output logic          found,
  output logic [IW-1:0] winner
);

  logic [2*N-1:0] rotated;

  always_comb begin
    // Doubling the vector lets a plain shift implement the wrap-around scan.
    rotated = {valid, valid} >> rr_ptr;
    found   = 1'b0;
    winner  = '0;
    for (int k = 0; k < N; k++) begin
      if (!found && rotated[k]) begin
        found  = 1'b1;
        winner = IW'(rr_wrap(int'(rr_ptr) + k, N));
      end
    end
  end

endmodule

// File: rtl/cbus_arbiter.sv
// Round-robin CBus arbiter granting whole transactions; valid at t -> oreq at t+1, one dead cycle after last.
// Non-granted requesters see ready=0 and must hold their request; the grant is held until ready&&last.
module cbus_arbiter
  import cbus_arbiter_pkg::*;
#(
  parameter int NUM_INPUTS = 2
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  cbus_req_t                     ireqs  [NUM_INPUTS],
  output cbus_resp_t                    iresps [NUM_INPUTS],
  output cbus_req_t                     oreq,
  input  cbus_resp_t                    oresp,
  output logic                          grant_busy,
  output logic [$clog2(NUM_INPUTS)-1:0] grant_index
);

  localparam int IW = $clog2(NUM_INPUTS);

  arb_state_e            state_q, state_d;
  logic [IW-1:0]         index_q, index_d;
  logic [IW-1:0]         rr_ptr_q, rr_ptr_d;
  logic [NUM_INPUTS-1:0] req_vld;
  logic                  pick_found;
  logic [IW-1:0]         pick_winner;

  always_comb begin
    req_vld = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      req_vld[i] = ireqs[i].valid;
    end
  end

  cbus_arbiter_rr_picker #(
    .N  (NUM_INPUTS),
    .IW (IW)
  ) u_rr_picker (
    .valid  (req_vld),
    .rr_ptr (rr_ptr_q),
    .found  (pick_found),
    .winner (pick_winner)
  );

  always_comb begin
    state_d  = state_q;
    index_d  = index_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          state_d = ST_BUSY;
          index_d = pick_winner;
        end
      end
      ST_BUSY: begin
        // index_q stays put after completion so debug shows the last grantee.
        if (oresp.ready && oresp.last) begin
          state_d  = ST_IDLE;
          rr_ptr_d = IW'(rr_wrap(int'(index_q) + 1, NUM_INPUTS));
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      index_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      index_q  <= index_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  always_comb begin
    oreq = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      iresps[i] = '0;
      if (state_q == ST_BUSY && index_q == IW'(i)) begin
        oreq      = ireqs[i];
        iresps[i] = oresp;
      end
    end
  end

  assign grant_busy  = (state_q == ST_BUSY);
  assign grant_index = index_q;

endmodule

// File: tb/tb_cbus_arbiter.sv
// Directed bench for cbus_arbiter: stimulus pushes expected grants/beats, a negedge monitor pops and compares.
module tb_cbus_arbiter;
  import cbus_arbiter_pkg::*;

  localparam int N = 2;

  logic       clk;
  logic       resetn;
  cbus_req_t  ireqs  [N];
  cbus_resp_t iresps [N];
  cbus_req_t  oreq;
  cbus_resp_t oresp;
  logic       grant_busy;
  logic [0:0] grant_index;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int          idx;
    logic [31:0] addr;
    logic        wr;
    logic [7:0]  len;
    int          cyc;
  } gexp_t;

  typedef struct {
    int          port;
    logic [31:0] data;
    logic        last;
    int          cyc;
  } bexp_t;

  gexp_t gq[$];
  bexp_t bq[$];
  logic  prev_busy;

  cbus_arbiter #(.NUM_INPUTS(N)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .ireqs       (ireqs),
    .iresps      (iresps),
    .oreq        (oreq),
    .oresp       (oresp),
    .grant_busy  (grant_busy),
    .grant_index (grant_index)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic wr, input logic [31:0] addr,
                         input logic [7:0] len);
    ireqs[i].valid    = v;
    ireqs[i].is_write = wr;
    ireqs[i].size     = 2'd2;
    ireqs[i].addr     = addr;
    ireqs[i].strobe   = wr ? 4'hf : 4'h0;
    ireqs[i].data     = addr ^ 32'h5a5a_5a5a;
    ireqs[i].len      = len;
  endtask

  task automatic exp_grant(input int idx, input logic [31:0] addr, input logic wr,
                           input logic [7:0] len, input int c);
    gexp_t g;
    g.idx = idx; g.addr = addr; g.wr = wr; g.len = len; g.cyc = c;
    gq.push_back(g);
  endtask

  // One response beat for grantee p, expected on iresps[p] in this same cycle.
  task automatic beat(input int p, input logic [31:0] d, input logic last);
    bexp_t b;
    oresp.ready = 1'b1;
    oresp.last  = last;
    oresp.data  = d;
    b.port = p; b.data = d; b.last = last; b.cyc = cyc;
    bq.push_back(b);
    tick();
    oresp = '0;
  endtask

  // Monitor: grant starts and response beats are popped from the scoreboard queues.
  initial begin
    prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        prev_busy = 1'b0;
      end else begin
        if (grant_busy && !prev_busy) begin
          if (gq.size() == 0) begin
            total++; bad++;
            $display("FAIL grant_unexpected act_idx=%0d act_addr=%h exp=none cyc=%0d",
                     grant_index, oreq.addr, cyc);
          end else begin
            gexp_t g;
            g = gq.pop_front();
            chk("grant", {16'(cyc), 4'(grant_index), 3'b0, oreq.is_write, oreq.len, oreq.addr},
                {16'(g.cyc), 4'(g.idx), 3'b0, g.wr, g.len, g.addr});
          end
        end
        prev_busy = grant_busy;
        for (int i = 0; i < N; i++) begin
          if (iresps[i].ready) begin
            if (bq.size() == 0) begin
              total++; bad++;
              $display("FAIL beat_unexpected act_port=%0d exp=none cyc=%0d", i, cyc);
            end else begin
              bexp_t b;
              b = bq.pop_front();
              chk("beat", {16'(cyc), 4'(i), 11'b0, iresps[i].last, iresps[i].data},
                  {16'(b.cyc), 4'(b.port), 11'b0, b.last, b.data});
            end
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0;
    oresp  = '0;
    for (int i = 0; i < N; i++) ireqs[i] = '0;

    // Reset with a valid request present.
    set_req(0, 1'b1, 1'b0, 32'h0000_1000, 8'd0);
    tick();
    tick();
    chk("rst_oreq_vld", 64'(oreq.valid), 64'd0);
    chk("rst_oreq_addr", 64'(oreq.addr), 64'd0);
    chk("rst_busy", 64'(grant_busy), 64'd0);
    chk("rst_idx", 64'(grant_index), 64'd0);
    chk("rst_rdy0", 64'(iresps[0].ready), 64'd0);
    chk("rst_rdy1", 64'(iresps[1].ready), 64'd0);
    resetn = 1'b1;
    ireqs[0] = '0;
    tick();
    chk("post_rst_busy", 64'(grant_busy), 64'd0);

    // Single read on port 1, ready+last three cycles after valid.
    set_req(1, 1'b1, 1'b0, 32'hbfc0_0000, 8'd0);
    exp_grant(1, 32'hbfc0_0000, 1'b0, 8'd0, cyc + 1);
    tick();
    chk("t2_addr_t1", 64'(oreq.addr), 64'hbfc0_0000);
    chk("t2_rdy_t1", 64'(iresps[1].ready), 64'd0);
    tick();
    chk("t2_addr_t2", 64'(oreq.addr), 64'hbfc0_0000);
    chk("t2_rdy_t2", 64'(iresps[1].ready), 64'd0);
    tick();
    begin
      bexp_t b;
      oresp.ready = 1'b1; oresp.last = 1'b1; oresp.data = 32'hcafe_0001;
      b.port = 1; b.data = 32'hcafe_0001; b.last = 1'b1; b.cyc = cyc;
      bq.push_back(b);
      #1;
      chk("t2_rdy_t3", 64'(iresps[1].ready), 64'd1);
      chk("t2_rdy0_t3", 64'(iresps[0].ready), 64'd0);
      tick();
      oresp = '0;
    end
    ireqs[1].valid = 1'b0;
    chk("t2_busy_t4", 64'(grant_busy), 64'd0);

    // Simultaneous requests with rr_ptr=0: 0, then 1, then 0 again.
    set_req(0, 1'b1, 1'b0, 32'h0000_2000, 8'd0);
    set_req(1, 1'b1, 1'b1, 32'h0000_3000, 8'd0);
    exp_grant(0, 32'h0000_2000, 1'b0, 8'd0, cyc + 1);
    tick();
    exp_grant(1, 32'h0000_3000, 1'b1, 8'd0, cyc + 2);
    beat(0, 32'h1111_0000, 1'b1);
    ireqs[0].valid = 1'b0;
    chk("t3_dead_cycle", 64'(grant_busy), 64'd0);
    tick();
    chk("t3_idx1", 64'(grant_index), 64'd1);
    set_req(0, 1'b1, 1'b0, 32'h0000_2004, 8'd0);
    exp_grant(0, 32'h0000_2004, 1'b0, 8'd0, cyc + 2);
    beat(1, 32'h2222_0000, 1'b1);
    ireqs[1].valid = 1'b0;
    tick();
    beat(0, 32'h1111_0001, 1'b1);
    ireqs[0].valid = 1'b0;

    // Four-beat write burst on port 0; port 1 arrives mid-burst and must wait.
    set_req(0, 1'b1, 1'b1, 32'h8000_0040, 8'd3);
    exp_grant(0, 32'h8000_0040, 1'b1, 8'd3, cyc + 1);
    tick();
    beat(0, 32'hb0b0_0000, 1'b0);
    set_req(1, 1'b1, 1'b0, 32'h0000_9000, 8'd0);
    tick();
    chk("t4_hold_idx", 64'(grant_index), 64'd0);
    chk("t4_hold_busy", 64'(grant_busy), 64'd1);
    beat(0, 32'hb0b0_0001, 1'b0);
    beat(0, 32'hb0b0_0002, 1'b0);
    chk("t4_hold_idx2", 64'(grant_index), 64'd0);
    exp_grant(1, 32'h0000_9000, 1'b0, 8'd0, cyc + 2);
    beat(0, 32'hb0b0_0003, 1'b1);
    ireqs[0].valid = 1'b0;
    tick();
    beat(1, 32'h9999_0000, 1'b1);
    ireqs[1].valid = 1'b0;

    // Spurious ready+last while idle: nothing routed, no state change.
    oresp.ready = 1'b1; oresp.last = 1'b1; oresp.data = 32'hdead_beef;
    #1;
    chk("t5_rdy0", 64'(iresps[0].ready), 64'd0);
    chk("t5_rdy1", 64'(iresps[1].ready), 64'd0);
    tick();
    chk("t5_busy", 64'(grant_busy), 64'd0);
    chk("t5_idx", 64'(grant_index), 64'd1);
    chk("t5_oreq_vld", 64'(oreq.valid), 64'd0);
    tick();
    oresp = '0;
    chk("t5_busy2", 64'(grant_busy), 64'd0);
    // rr_ptr must still be 0 after the spurious beats.
    set_req(0, 1'b1, 1'b0, 32'h0000_4000, 8'd0);
    set_req(1, 1'b1, 1'b0, 32'h0000_5000, 8'd0);
    exp_grant(0, 32'h0000_4000, 1'b0, 8'd0, cyc + 1);
    tick();
    beat(0, 32'h4444_0000, 1'b1);
    ireqs[0].valid = 1'b0;

    // Port 1 burst (rr_ptr=1), reset after beat 2 of 4.
    set_req(1, 1'b1, 1'b1, 32'h0000_6000, 8'd3);
    exp_grant(1, 32'h0000_6000, 1'b1, 8'd3, cyc + 1);
    tick();
    beat(1, 32'h6666_0000, 1'b0);
    beat(1, 32'h6666_0001, 1'b0);
    resetn = 1'b0;
    tick();
    oresp.ready = 1'b1; oresp.last = 1'b1; oresp.data = 32'h0bad_0bad;
    #1;
    chk("t6_busy", 64'(grant_busy), 64'd0);
    chk("t6_oreq_vld", 64'(oreq.valid), 64'd0);
    chk("t6_oreq_addr", 64'(oreq.addr), 64'd0);
    chk("t6_rdy1", 64'(iresps[1].ready), 64'd0);
    resetn = 1'b1;
    oresp  = '0;
    // Both valid: cleared rr_ptr must favour port 0.
    set_req(0, 1'b1, 1'b0, 32'h0000_7000, 8'd0);
    exp_grant(0, 32'h0000_7000, 1'b0, 8'd0, cyc + 1);
    tick();
    exp_grant(1, 32'h0000_6000, 1'b1, 8'd3, cyc + 2);
    beat(0, 32'h7777_0000, 1'b1);
    ireqs[0].valid = 1'b0;
    tick();
    for (int k = 0; k < 4; k++) begin
      beat(1, 32'h6666_1000 + 32'(k), (k == 3));
    end
    ireqs[1].valid = 1'b0;
    tick();
    tick();
    chk("end_busy", 64'(grant_busy), 64'd0);
    chk("gq_empty", 64'(gq.size()), 64'd0);
    chk("bq_empty", 64'(bq.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
